// File: rtl/datamem_if.sv
// MEM-stage data-memory port: one load and one store request per cycle.
// The datapath is the master. The responder is the slave.
interface datamem_if #(
    parameter int ADDR_W = 7
);
    logic [ADDR_W-1:0] datamem_rd_addr0;
    logic              datamem_rd_en;
    logic [31:0]       datamem_rd_dout0;
    logic [ADDR_W-1:0] datamem_wr_addr0;
    logic [31:0]       datamem_wr_din0;
    logic              datamem_we0;
    logic [2:0]        datamem_wr_strb;

    modport master (
        output datamem_rd_addr0, datamem_rd_en, datamem_wr_addr0,
               datamem_wr_din0, datamem_we0, datamem_wr_strb,
        input  datamem_rd_dout0
    );
    modport slave (
        input  datamem_rd_addr0, datamem_rd_en, datamem_wr_addr0,
               datamem_wr_din0, datamem_we0, datamem_wr_strb,
        output datamem_rd_dout0
    );
endinterface

// File: rtl/datamem_responder.sv
// Data-memory responder: a FIFO store buffer drains into a byte-lane word array
// on non-load cycles. Loads are combinational and use byte-accurate bypass.
module datamem_responder #(
    parameter int ADDR_W   = 7,
    parameter int SB_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    datamem_if.slave                  bus,
    output logic [$clog2(SB_DEPTH):0] sb_count,
    output logic                      sb_empty,
    output logic                      sb_overflow
);
    localparam int PW    = $clog2(SB_DEPTH);
    localparam int CW    = PW + 1;
    localparam int WORDS = 2 ** ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [3:0]        mask;
        logic [31:0]       data;
    } sb_entry_t;

    sb_entry_t         sb_q [SB_DEPTH];
    sb_entry_t         new_e;
    sb_entry_t         head_e;
    logic [PW-1:0]     head, tail, idx;
    logic [CW-1:0]     count;
    logic              ovf;
    logic              full, drain, push;
    logic [31:0]       arr_word, merged;

    // Strobe decode. The illegal pattern 010 falls through to a full-word store.
    always_comb begin
        new_e.addr = bus.datamem_wr_addr0;
        new_e.mask = 4'b1111;
        new_e.data = bus.datamem_wr_din0;
        casez (bus.datamem_wr_strb)
            3'b1??: begin
                new_e.mask = 4'b0001 << bus.datamem_wr_strb[1:0];
                new_e.data = {4{bus.datamem_wr_din0[7:0]}};
            end
            3'b0?1: begin
                new_e.mask = bus.datamem_wr_strb[1] ? 4'b1100 : 4'b0011;
                new_e.data = {2{bus.datamem_wr_din0[15:0]}};
            end
            default: ;
        endcase
    end

    assign head_e = sb_q[head];
    assign full   = (count == CW'(SB_DEPTH));
    // Pending stores are discarded on reset, so drain is gated by rst.
    assign drain  = !rst && !bus.datamem_rd_en && (count != '0);
    // When full, a same-cycle drain frees the slot the push lands in.
    assign push   = bus.datamem_we0 && (!full || drain);

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            if (push) begin
                sb_q[tail] <= new_e;
                tail       <= tail + 1'b1;
            end
            if (drain)
                head <= head + 1'b1;
            count <= count + CW'(push) - CW'(drain);
            if (bus.datamem_we0 && !push)
                ovf <= 1'b1;
        end
    end

    // One byte-wide array per lane, so a masked drain touches only its lanes.
    for (genvar b = 0; b < 4; b++) begin : g_lane
        logic [7:0] lane_mem [WORDS];
        always_ff @(posedge clk)
            if (drain && head_e.mask[b])
                lane_mem[head_e.addr] <= head_e.data[8*b +: 8];
        assign arr_word[8*b +: 8] = lane_mem[bus.datamem_rd_addr0];
    end

    // Oldest-to-newest overlay so the newest buffered byte wins.
    always_comb begin
        merged = arr_word;
        idx    = '0;
        for (int k = 0; k < SB_DEPTH; k++) begin
            idx = head + PW'(k);
            if (CW'(k) < count && sb_q[idx].addr == bus.datamem_rd_addr0)
                for (int b = 0; b < 4; b++)
                    if (sb_q[idx].mask[b])
                        merged[8*b +: 8] = sb_q[idx].data[8*b +: 8];
        end
    end

    assign bus.datamem_rd_dout0 = merged;
    assign sb_count             = count;
    assign sb_empty             = (count == '0);
    assign sb_overflow          = ovf;
endmodule

// File: doc/datamem_responder.md
Name: datamem_responder

Overview:
Data-memory responder on the datapath's MEM-stage memory port. Decodes the 3-bit write-strobe encoding and lane-aligns raw store data. Posts stores into a small FIFO store buffer that drains into a single-ported word array on non-load cycles. Loads return combinationally in the same cycle, with byte-accurate bypass from pending buffered stores.

Parameters:
ADDR_W, 7, word-address width; the array holds 2^ADDR_W 32-bit words.
SB_DEPTH, 4, store-buffer entries (power of 2, at least 2).

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
datamem_rd_addr0  in  ADDR_W  load word index
datamem_rd_en  in  1  load in MEM stage this cycle
datamem_rd_dout0  out  32  load word after bypass merge, combinational
datamem_wr_addr0  in  ADDR_W  store word index (word n = bytes 4n..4n+3)
datamem_wr_din0  in  32  raw store data, unshifted rs2 value
datamem_we0  in  1  store in MEM stage this cycle
datamem_wr_strb  in  3  000 word; {0,a1,1} half at a1; {1,a1,a0} byte at {a1,a0}
sb_count  out  $clog2(SB_DEPTH)+1  valid buffer entries
sb_empty  out  1  sb_count==0
sb_overflow  out  1  sticky flag: a store was dropped

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: sb_count=0, sb_empty=1, sb_overflow=0; head and tail pointers 0.
- Reset does not touch the array, which is zero at time 0. Stores pending at reset are discarded, never drained.
- Strobe decode to byte mask and lane data:
  - 000 -> mask 1111, data=din.
  - 0,a1,1 -> mask 0011 if a1=0 else 1100; data={din[15:0],din[15:0]}.
  - 1,a1,a0 -> mask bit {a1,a0} only; data=din[7:0] replicated x4.
  - 010 (illegal) -> treated as word.
- Buffer entry fields: {addr, mask[3:0], data[31:0]}.
- Push: when we0=1 and the entry can be accepted (see full-buffer rules below), the entry is written at tail on the clock edge. It is visible to bypass from the next cycle.
- Drain: when rd_en=0 and sb_count!=0, the head entry is written into array[addr] on the clock edge. Only bytes set in mask are written; other bytes are preserved. Head advances.
- Drain is suppressed whenever rd_en=1, because the array port is busy with the load.
- Simultaneous push and drain in one cycle: sb_count is unchanged.
- Full buffer (sb_count==SB_DEPTH) with we0=1:
  - If rd_en=0, the drain frees a slot the same cycle (pop before push) and the store is accepted.
  - If rd_en=1, the store is dropped and sb_overflow is set until rst.
- Read path (combinational): start from array[rd_addr]. Overlay each valid entry whose addr==rd_addr, oldest to newest, byte by byte under its mask. The newest write to a byte wins.
- The store being pushed in the current cycle is not included in that cycle's read.
- With rd_en=0, rd_dout0 still reflects the merged value for rd_addr. The datapath ignores it.
- Pointers wrap modulo SB_DEPTH.
- sb_count never exceeds SB_DEPTH and never goes below 0.
- Timing: load latency 0 cycles; store-to-load visibility 1 cycle via bypass; store-to-array 1 cycle minimum, unbounded under back-to-back loads.

Test Plan:
1. rst, then word store addr 3 din 0xDEADBEEF strb 000, then load addr 3 next cycle with rd_en=1 -> rd_dout0=0xDEADBEEF via bypass, sb_count=1. Release rd_en -> after 1 cycle sb_count=0 and array[3]=0xDEADBEEF.
2. Array[5]=0x11223344; byte store din 0x000000AA strb 110 held in the buffer by rd_en=1 on addr 5 -> rd_dout0=0x11AA3344. After drain, array[5]=0x11AA3344.
3. Half store addr 7 din 0x0000BEEF strb 011, then byte store addr 7 din 0x55 strb 101, both buffered -> read addr 7 over zero memory gives 0xBEEF5500 (newest byte wins).
4. Four stores to addrs 0..3 while rd_en=1 throughout (4-entry FIFO) -> sb_count=4. A fifth store with rd_en=1 -> dropped, sb_overflow=1, sb_count=4. Then a store with rd_en=0 -> accepted, sb_count stays 4.
5. Buffer holds 3 entries; assert rst for 1 cycle -> sb_count=0, sb_empty=1, sb_overflow=0, array unchanged, reads show no bypass data.
6. 2^ADDR_W+ stores with rd_en alternating 0/1 -> pointers wrap. Final array matches a reference byte model, and sb_overflow stays 0.
